// File: rtl/noc_traffic_gen.sv
// Synthetic per-node traffic source driving one NoC router injection port.
module noc_traffic_gen #(
    parameter int unsigned ID        = 0,
    parameter int unsigned NODES     = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned DATA_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ID_W-1:0]   fixed_dest,
    input  logic [15:0]       pkt_limit,
    input  logic [7:0]        gap,
    input  logic              full,
    input  logic              almost_full,
    output logic [DATA_W-1:0] dataOut,
    output logic              write,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sent_count
);

    localparam int unsigned    SEQ_W     = DATA_W - 2 * ID_W - 1;
    localparam logic [ID_W-1:0] MY_ID    = ID_W'(ID);
    localparam logic [ID_W-1:0] RR_INIT  = ID_W'((ID + 1) % NODES);
    localparam logic [15:0]    LFSR_INIT = LFSR_SEED ^ 16'(ID);
    localparam logic [15:0]    LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    // Increment a node index modulo NODES.
    function automatic logic [ID_W-1:0] inc_mod(input logic [ID_W-1:0] x);
        logic [ID_W:0] t;
        t = {1'b0, x} + (ID_W+1)'(1);
        if (t >= (ID_W+1)'(NODES)) t = '0;
        return t[ID_W-1:0];
    endfunction

    // Next round-robin destination, skipping this node.
    function automatic logic [ID_W-1:0] rr_step(input logic [ID_W-1:0] x);
        logic [ID_W-1:0] n;
        n = inc_mod(x);
        if (n == MY_ID) n = inc_mod(n);
        return n;
    endfunction

    // Fold LFSR low bits into a legal destination other than this node.
    function automatic logic [ID_W-1:0] lfsr_dest(input logic [15:0] l);
        logic [ID_W:0]   v;
        logic [ID_W-1:0] d;
        v = {1'b0, l[ID_W-1:0]};
        if (v >= (ID_W+1)'(NODES)) v = v - (ID_W+1)'(NODES);
        d = v[ID_W-1:0];
        if (d == MY_ID) d = inc_mod(d);
        return d;
    endfunction

    state_t          state, state_nxt;
    logic [1:0]      cfg_mode, cfg_mode_nxt;
    logic [ID_W-1:0] cfg_fixed, cfg_fixed_nxt;
    logic [15:0]     cfg_limit, cfg_limit_nxt;
    logic [7:0]      cfg_gap, cfg_gap_nxt;
    logic [7:0]      gap_cnt, gap_cnt_nxt;
    logic [SEQ_W-1:0] seq, seq_nxt;
    logic [15:0]     lfsr, lfsr_nxt;
    logic [ID_W-1:0] rr_dest, rr_dest_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic            write_nxt, busy_nxt, done_nxt;
    logic [15:0]     sent_nxt;

    logic            stall_c, issue_c, last_c, start_ok_c;
    logic [ID_W-1:0] dest_sel_c;

    // Backpressure accounts for the flit already presented to the router.
    assign stall_c    = (write & almost_full) | (~write & full);
    assign issue_c    = (state == RUN) && enable && !stall_c;
    assign last_c     = (cfg_limit != 16'd0) && (16'(sent_count + 16'd1) == cfg_limit);
    assign start_ok_c = start && ((state == IDLE) || (state == DONE));

    // Destination chosen by the latched mode; mode 3 behaves as fixed.
    always_comb begin
        dest_sel_c = cfg_fixed;
        case (cfg_mode)
            2'd1:    dest_sel_c = rr_dest;
            2'd2:    dest_sel_c = lfsr_dest(lfsr);
            default: dest_sel_c = cfg_fixed;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cfg_mode   <= '0;
            cfg_fixed  <= '0;
            cfg_limit  <= '0;
            cfg_gap    <= '0;
            gap_cnt    <= '0;
            seq        <= '0;
            lfsr       <= LFSR_INIT;
            rr_dest    <= RR_INIT;
            dataOut    <= '0;
            write      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
        end else begin
            state      <= state_nxt;
            cfg_mode   <= cfg_mode_nxt;
            cfg_fixed  <= cfg_fixed_nxt;
            cfg_limit  <= cfg_limit_nxt;
            cfg_gap    <= cfg_gap_nxt;
            gap_cnt    <= gap_cnt_nxt;
            seq        <= seq_nxt;
            lfsr       <= lfsr_nxt;
            rr_dest    <= rr_dest_nxt;
            dataOut    <= data_nxt;
            write      <= write_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sent_count <= sent_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok_c) state_nxt = RUN;
            RUN: begin
                if (issue_c) begin
                    if (last_c)                 state_nxt = DONE;
                    else if (cfg_gap != 8'd0)   state_nxt = GAP;
                    else                        state_nxt = RUN;
                end
            end
            GAP:     if (gap_cnt <= 8'd1) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        cfg_mode_nxt  = cfg_mode;
        cfg_fixed_nxt = cfg_fixed;
        cfg_limit_nxt = cfg_limit;
        cfg_gap_nxt   = cfg_gap;
        gap_cnt_nxt   = gap_cnt;
        seq_nxt       = seq;
        lfsr_nxt      = lfsr;
        rr_dest_nxt   = rr_dest;
        data_nxt      = dataOut;
        write_nxt     = 1'b0;
        sent_nxt      = sent_count;

        if (start_ok_c) begin
            cfg_mode_nxt  = mode;
            cfg_fixed_nxt = fixed_dest;
            cfg_limit_nxt = pkt_limit;
            cfg_gap_nxt   = gap;
            sent_nxt      = '0;
            seq_nxt       = '0;
            rr_dest_nxt   = RR_INIT;
        end

        if (issue_c) begin
            write_nxt = 1'b1;
            data_nxt  = {seq, MY_ID, dest_sel_c, 1'b1};
            seq_nxt   = seq + SEQ_W'(1);
            if (sent_count != 16'hFFFF) sent_nxt = sent_count + 16'd1;
            if (cfg_mode == 2'd1) rr_dest_nxt = rr_step(rr_dest);
            if (cfg_mode == 2'd2) lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            gap_cnt_nxt = cfg_gap;
        end

        if (state == GAP) gap_cnt_nxt = gap_cnt - 8'd1;

        busy_nxt = (state_nxt == RUN) || (state_nxt == GAP);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed self-checking bench for noc_traffic_gen (ID=1, NODES=4, 16-bit flits).
module tb_noc_traffic_gen;

    logic        clk = 1'b0;
    logic        reset, start, enable, full, almost_full;
    logic [1:0]  mode, fixed_dest;
    logic [15:0] pkt_limit;
    logic [7:0]  gap;
    logic [15:0] dataOut;
    logic        write, busy, done;
    logic [15:0] sent_count;

    int checks = 0;
    int errors = 0;

    noc_traffic_gen #(.ID(1), .NODES(4), .ID_W(2), .DATA_W(16), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .mode(mode),
        .fixed_dest(fixed_dest), .pkt_limit(pkt_limit), .gap(gap), .full(full),
        .almost_full(almost_full), .dataOut(dataOut), .write(write), .busy(busy),
        .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flit(input int s, input int d);
        logic [10:0] s11;
        logic [1:0]  d2;
        s11 = 11'(s);
        d2  = 2'(d);
        return {s11, 2'd1, d2, 1'b1};
    endfunction

    initial begin
        int          rr_exp[6];
        logic [15:0] lf;
        logic [1:0]  v;
        int          lseq;
        logic        en;

        rr_exp = '{2, 3, 0, 2, 3, 0};
        reset = 1'b1; start = 1'b0; enable = 1'b0; full = 1'b0; almost_full = 1'b0;
        mode = 2'd0; fixed_dest = 2'd0; pkt_limit = 16'd0; gap = 8'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sent", 32'(sent_count), 32'd0);
        chk("rst_data", 32'(dataOut), 32'd0);

        // Round-robin run of six back-to-back flits.
        mode = 2'd1; pkt_limit = 16'd6; gap = 8'd0; enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("rr_start_write", 32'(write), 32'd0);
        chk("rr_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_write%0d", i), 32'(write), 32'd1);
            chk($sformatf("rr_flit%0d", i), 32'(dataOut), 32'(flit(i, rr_exp[i])));
        end
        step();
        chk("rr_end_write", 32'(write), 32'd0);
        chk("rr_end_done", 32'(done), 32'd1);
        chk("rr_end_busy", 32'(busy), 32'd0);
        chk("rr_end_sent", 32'(sent_count), 32'd6);

        // Fixed destination with a two-cycle gap: writes on t, t+3, t+6.
        mode = 2'd0; fixed_dest = 2'd3; gap = 8'd2; pkt_limit = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            chk($sformatf("gap_write%0d", c), 32'(write), 32'((c % 3 == 0) && (c <= 6)));
            if (c % 3 == 0 && c <= 6)
                chk($sformatf("gap_flit%0d", c), 32'(dataOut), 32'(flit(c / 3, 3)));
            if (c == 5) chk("gap_done_early", 32'(done), 32'd0);
            if (c == 6) chk("gap_done", 32'(done), 32'd1);
        end

        // Backpressure: almost_full while writing, then full while idle.
        mode = 2'd0; fixed_dest = 2'd2; gap = 8'd0; pkt_limit = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("bp_first", 32'(dataOut), 32'(flit(0, 2)));
        almost_full = 1'b1;
        step();
        chk("bp_af_stall", 32'(write), 32'd0);
        almost_full = 1'b0; full = 1'b1;
        step();
        chk("bp_full_stall0", 32'(write), 32'd0);
        step();
        chk("bp_full_stall1", 32'(write), 32'd0);
        full = 1'b0;
        step();
        chk("bp_resume_write", 32'(write), 32'd1);
        chk("bp_resume_flit", 32'(dataOut), 32'(flit(1, 2)));
        chk("bp_resume_sent", 32'(sent_count), 32'd2);

        // Reset mid-run at sent_count=4, then a fresh start from seq 0.
        step(); step();
        chk("mid_sent4", 32'(sent_count), 32'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sent", 32'(sent_count), 32'd0);
        chk("mid_rst_data", 32'(dataOut), 32'd0);
        step();
        chk("mid_idle_write", 32'(write), 32'd0);
        chk("mid_idle_busy", 32'(busy), 32'd0);
        pkt_limit = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("restart_flit", 32'(dataOut), 32'(flit(0, 2)));
        chk("restart_done", 32'(done), 32'd1);

        // LFSR destinations with enable granted one cycle in four.
        mode = 2'd2; pkt_limit = 16'd0; enable = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        lf = 16'hACE1 ^ 16'h0001;
        lseq = 0;
        for (int k = 0; k < 40; k++) begin
            en = (k % 4 == 0);
            enable = en;
            step();
            chk($sformatf("lfsr_write%0d", k), 32'(write), 32'(en));
            if (en) begin
                v = lf[1:0];
                if (v == 2'd1) v = 2'd2;
                chk($sformatf("lfsr_flit%0d", lseq), 32'(dataOut), 32'(flit(lseq, int'(v))));
                chk($sformatf("lfsr_not_self%0d", lseq), 32'(dataOut[2:1] != 2'd1), 32'd1);
                lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
                lseq++;
            end
        end

        // Sequence wrap over 2049 flits; a start mid-run must be ignored.
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode = 2'd0; fixed_dest = 2'd0; pkt_limit = 16'd2049; gap = 8'd0; enable = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 2049; n++) begin
            start = (n == 10);
            step();
            chk($sformatf("wrap_write%0d", n), 32'(write), 32'd1);
            chk($sformatf("wrap_seq%0d", n), 32'(dataOut[15:5]), 32'(n % 2048));
        end
        start = 1'b0;
        chk("wrap_last_flit", 32'(dataOut), 32'h0009);
        step();
        chk("wrap_end_write", 32'(write), 32'd0);
        chk("wrap_end_done", 32'(done), 32'd1);
        chk("wrap_end_sent", 32'(sent_count), 32'd2049);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
